// File: rtl/serial_frame_feeder_if.sv
// Word-in / bit-out handshake bundle between a word source and the serial frame feeder.
interface serial_frame_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, busy, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, busy, frame_done
  );
endinterface

// File: rtl/serial_frame_feeder.sv
// Parallel-to-serial feeder for the sequence detector: one bit per clock,
// frame_done on the last bit, optional forced idle gap between frames.
//
// state | meaning
// IDLE  | waiting for a word, din_ready=1
// SHIFT | presenting bits 0..WIDTH-1 of the captured word
// GAP   | forced idle zeros after a frame, GAP_CYCLES long
module serial_frame_feeder #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_frame_feeder_if.slave  feed
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gap_q, gap_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             last_bit;
  logic             din_ready;
  logic             hs;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last_bit  = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
  // Without a gap the last-bit cycle also accepts, giving a bubble-free stream.
  assign din_ready = reset && ((state_q == IDLE) || ((GAP_CYCLES == 0) && last_bit));
  assign hs        = feed.din_valid && din_ready;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    frame_done_d = 1'b0;
    if (hs) begin
      state_d      = SHIFT;
      shreg_d      = feed.din;
      cnt_d        = '0;
      sout_d       = head_bit(feed.din);
      sout_valid_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        SHIFT: begin
          if (last_bit) begin
            cnt_d = '0;
            if (GAP_CYCLES != 0) begin
              state_d = GAP;
              gap_d   = 8'(GAP_CYCLES - 1);
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d        = cnt_q + CNT_W'(1);
            shreg_d      = advance(shreg_q);
            sout_d       = head_bit(advance(shreg_q));
            sout_valid_d = 1'b1;
            frame_done_d = (cnt_q == CNT_W'(WIDTH - 2));
          end
        end
        GAP: begin
          if (gap_q == 8'd0) state_d = IDLE;
          else               gap_d   = gap_q - 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign feed.din_ready  = din_ready;
  assign feed.sout       = sout_q;
  assign feed.sout_valid = sout_valid_q;
  assign feed.frame_done = frame_done_q;
  assign feed.busy       = busy_q;
endmodule

// File: tb/tb_serial_frame_feeder.sv
// Bench for serial_frame_feeder: three configurations driven in lockstep,
// each compared every cycle against a frame/bit-index reference model.
module tb_serial_frame_feeder;
  localparam int W  = 8;
  localparam int NI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_frame_feeder_if #(.WIDTH(W)) ifa ();
  serial_frame_feeder_if #(.WIDTH(W)) ifb ();
  serial_frame_feeder_if #(.WIDTH(W)) ifc ();

  serial_frame_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .reset(rst_n), .feed(ifa));
  serial_frame_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .reset(rst_n), .feed(ifb));
  serial_frame_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .reset(rst_n), .feed(ifc));

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;
  int cyc_n = 0;

  // Reference: index of the bit on sout (-1 = no frame) and gap cycles left.
  int         m_idx [NI];
  int         m_gap [NI];
  logic [W-1:0] m_word [NI];
  logic       m_rdy [NI];

  function automatic int gap_of(input int i);
    return (i == 1) ? 3 : 0;
  endfunction

  function automatic bit msb_of(input int i);
    return (i != 2);
  endfunction

  function automatic logic exp_ready(input int i);
    return rst_n && ((m_idx[i] < 0 && m_gap[i] == 0) ||
                     (gap_of(i) == 0 && m_idx[i] == W - 1));
  endfunction

  task automatic chk(input string tag, input int i, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s inst%0d cycle %0d: got %b expected %b", tag, i, cyc_n, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic rdy, input logic so,
                            input logic sv, input logic fd, input logic bz);
    int   k;
    logic eb;
    k  = m_idx[i];
    eb = 1'b0;
    if (k >= 0) eb = msb_of(i) ? m_word[i][W-1-k] : m_word[i][k];
    chk("din_ready",  i, rdy, m_rdy[i]);
    chk("sout",       i, so,  eb);
    chk("sout_valid", i, sv,  k >= 0);
    chk("frame_done", i, fd,  k == W - 1);
    chk("busy",       i, bz,  (k >= 0) || (m_gap[i] > 0));
  endtask

  task automatic model_edge(input int i, input logic v, input logic [W-1:0] d,
                            input logic r, input logic rdy);
    logic hs;
    if (!r) begin
      m_idx[i] = -1;
      m_gap[i] = 0;
    end else begin
      hs = v && rdy;
      if (m_idx[i] == W - 1) begin
        m_idx[i] = -1;
        if (!hs) m_gap[i] = gap_of(i);
      end else if (m_idx[i] >= 0) begin
        m_idx[i]++;
      end else if (m_gap[i] > 0) begin
        m_gap[i]--;
      end
      if (hs) begin
        m_word[i] = d;
        m_idx[i]  = 0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d);
    rst_n = r;
    ifa.din = d; ifa.din_valid = v;
    ifb.din = d; ifb.din_valid = v;
    ifc.din = d; ifc.din_valid = v;
    #1;
    for (int i = 0; i < NI; i++) m_rdy[i] = exp_ready(i);
    check_inst(0, ifa.din_ready, ifa.sout, ifa.sout_valid, ifa.frame_done, ifa.busy);
    check_inst(1, ifb.din_ready, ifb.sout, ifb.sout_valid, ifb.frame_done, ifb.busy);
    check_inst(2, ifc.din_ready, ifc.sout, ifc.sout_valid, ifc.frame_done, ifc.busy);
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i, v, d, r, m_rdy[i]);
    cyc_n++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_idx[i]  = -1;
      m_gap[i]  = 0;
      m_word[i] = '0;
      m_rdy[i]  = 1'b0;
    end
    ifa.din = '0; ifa.din_valid = 1'b0;
    ifb.din = '0; ifb.din_valid = 1'b0;
    ifc.din = '0; ifc.din_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // Single frame B2, then 0F offered in the last-bit cycle.
    cyc(1'b1, 1'b1, 8'hB2);
    repeat (7) cyc(1'b1, 1'b0, 8'($urandom));
    cyc(1'b1, 1'b1, 8'h0F);
    repeat (12) cyc(1'b1, 1'b0, 8'($urandom));

    // din_valid held high: contiguous streams on a/c, gapped on b.
    cyc(1'b1, 1'b1, 8'hB2);
    repeat (30) cyc(1'b1, 1'b1, 8'($urandom));
    repeat (15) cyc(1'b1, 1'b0, 8'h00);

    // Reset after three bits of FF, then a clean A5.
    cyc(1'b1, 1'b1, 8'hFF);
    repeat (3) cyc(1'b1, 1'b0, 8'hFF);
    cyc(1'b0, 1'b0, 8'hFF);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hA5);
    repeat (12) cyc(1'b1, 1'b0, 8'h00);

    // Word offered mid-frame is ignored.
    cyc(1'b1, 1'b1, 8'hB2);
    repeat (3) cyc(1'b1, 1'b0, 8'hB2);
    cyc(1'b1, 1'b1, 8'h00);
    repeat (12) cyc(1'b1, 1'b0, 8'h00);

    // Random traffic with occasional resets.
    repeat (600)
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0), 8'($urandom));
    repeat (15) cyc(1'b1, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
